// File: rtl/ppu_bg_fifo_if.sv
// Push/pop bus between the background fetcher, the background FIFO and the pixel mixer.
// The pixel travels as a plain vector so this file has no package dependency.
// PX_W must equal $bits(ppu_pkg::ppu_pixel_t).
interface ppu_bg_fifo_if #(
  parameter int DEPTH = 16,
  parameter int PX_W  = 13
);
  logic                   push_en;
  logic [PX_W-1:0]        push_px;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   pop_en;
  logic [PX_W-1:0]        out_px;
  logic                   out_valid;

  modport master (
    output push_en, push_px, pop_en,
    input  full, empty, count, out_px, out_valid
  );

  modport slave (
    input  push_en, push_px, pop_en,
    output full, empty, count, out_px, out_valid
  );
endinterface

// File: rtl/ppu_bg_fifo.sv
// Background pixel FIFO for the PPU mode-3 pipeline: a circular buffer fed by the
// background fetcher and drained by the pixel mixer. It also drops the first SCX[2:0]
// pixels of every line (fine scroll) and can be flushed on window start.
package ppu_pkg;
  typedef struct packed {
    logic       valid;
    logic       bg_prio;
    logic [5:0] spr_idx;
    logic [2:0] palette;
    logic [1:0] color;
  } ppu_pixel_t;
endpackage

// DEPTH must be a power of two and at least 8 so that the pointers wrap naturally.
module ppu_bg_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_dotEn,
  input  logic         i_flush,
  input  logic         i_lineStart,
  input  logic [2:0]   i_scxFine,
  output logic         o_discarding,
  output logic         o_overflow,
  output logic         o_underflow,
  ppu_bg_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ppu_pixel_t       r_storage [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_discardCnt;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_discarding;
  logic w_outValid;
  logic w_push;
  logic w_pushDropped;
  logic w_discard;
  logic w_pop;
  logic w_popIgnoredEmpty;
  logic w_advance;

  // Status is taken from registered state only, so push_en/pop_en never reach full/empty.
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_discarding = (r_discardCnt != 3'd0);
  assign w_outValid   = !w_empty && !w_discarding;

  // Discard takes priority over the mixer's pop; both advance the read pointer.
  assign w_push            = i_dotEn && bus.push_en && !w_full;
  assign w_pushDropped     = i_dotEn && bus.push_en && w_full;
  assign w_discard         = i_dotEn && w_discarding && !w_empty;
  assign w_pop             = i_dotEn && bus.pop_en && w_outValid;
  assign w_popIgnoredEmpty = i_dotEn && bus.pop_en && w_empty;
  assign w_advance         = w_pop || w_discard;

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.out_valid = w_outValid;
  assign bus.out_px    = w_empty ? '0 : r_storage[r_rdPtr];
  assign o_discarding  = w_discarding;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

  // Pixel storage: written at the write pointer on every accepted push; a flush blocks the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_storage[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_storage[r_wrPtr] <= bus.push_px;
    end
  end

  // Pointers and occupancy; a push and a pop/discard in the same dot leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_advance) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_advance) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_advance) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Fine-scroll counter: line_start reloads it even during a flush or with dot_en low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_discardCnt <= 3'd0;
    end else if (i_lineStart) begin
      r_discardCnt <= i_scxFine;
    end else if (i_flush) begin
      r_discardCnt <= 3'd0;
    end else if (w_discard) begin
      r_discardCnt <= r_discardCnt - 3'd1;
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushDropped) begin
        r_overflow <= 1'b1;
      end
      if (w_popIgnoredEmpty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_fifo.sv
// Self-checking bench for ppu_bg_fifo: a vector table, directed multi-cycle sequences
// and a randomized run, all cross-checked against a queue-based reference model.
module tb_ppu_bg_fifo;
  import ppu_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       dotEn;
  logic       flush;
  logic       lineStart;
  logic [2:0] scxFine;
  logic       discarding;
  logic       overflow;
  logic       underflow;

  ppu_bg_fifo_if #(.DEPTH(DEPTH), .PX_W($bits(ppu_pixel_t))) bus ();

  ppu_bg_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_dotEn      (dotEn),
    .i_flush      (flush),
    .i_lineStart  (lineStart),
    .i_scxFine    (scxFine),
    .o_discarding (discarding),
    .o_overflow   (overflow),
    .o_underflow  (underflow),
    .bus          (bus.slave)
  );

  // Dot clock, 10 time units per dot.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a queue plus the scroll counter and sticky flags.
  ppu_pixel_t mq[$];
  int         mDisc;
  bit         mOvf;
  bit         mUnf;

  typedef struct {
    logic       de;
    logic       fl;
    logic       pe;
    logic [5:0] spr;
    logic       pop;
    int         expCount;
    logic       expEmpty;
    logic       expValid;
    logic [5:0] expHeadSpr;
    logic [1:0] expHeadCol;
    logic       expUnf;
  } vec_t;

  vec_t vecs[$];

  function automatic ppu_pixel_t mkPx(input int i);
    ppu_pixel_t p;
    p.valid   = 1'b1;
    p.bg_prio = i[0];
    p.spr_idx = i[5:0];
    p.palette = ~i[2:0];
    p.color   = i[1:0];
    return p;
  endfunction

  function automatic void modelReset();
    mq.delete();
    mDisc = 0;
    mOvf  = 1'b0;
    mUnf  = 1'b0;
  endfunction

  // One dot of the model, decided entirely on the state before the edge.
  function automatic void modelStep(input logic de, input logic fl, input logic ls,
                                    input logic [2:0] scx, input logic pe,
                                    input ppu_pixel_t px, input logic pop);
    bit wasFull  = (mq.size() == DEPTH);
    bit wasEmpty = (mq.size() == 0);
    bit valid    = !wasEmpty && (mDisc == 0);
    if (fl) begin
      mq.delete();
      mOvf  = 1'b0;
      mUnf  = 1'b0;
      mDisc = ls ? int'(scx) : 0;
      return;
    end
    if (de && mDisc != 0 && !wasEmpty) begin
      void'(mq.pop_front());
      mDisc--;
    end else if (de && pop && valid) begin
      void'(mq.pop_front());
    end else if (de && pop && wasEmpty) begin
      mUnf = 1'b1;
    end
    if (de && pe) begin
      if (wasFull) mOvf = 1'b1;
      else mq.push_back(px);
    end
    if (ls) mDisc = int'(scx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    ppu_pixel_t expPx;
    expPx = (mq.size() != 0) ? mq[0] : '0;
    check({tag, ".count"},      32'(bus.count),     32'(mq.size()));
    check({tag, ".empty"},      32'(bus.empty),     32'(mq.size() == 0));
    check({tag, ".full"},       32'(bus.full),      32'(mq.size() == DEPTH));
    check({tag, ".outValid"},   32'(bus.out_valid), 32'(mq.size() != 0 && mDisc == 0));
    check({tag, ".outPx"},      32'(bus.out_px),    32'(expPx));
    check({tag, ".discarding"}, 32'(discarding),    32'(mDisc != 0));
    check({tag, ".overflow"},   32'(overflow),      32'(mOvf));
    check({tag, ".underflow"},  32'(underflow),     32'(mUnf));
  endtask

  // Drive one dot of inputs, clock it, step the model and compare.
  task automatic applyStimulus(input logic de, input logic fl, input logic ls,
                               input logic [2:0] scx, input logic pe,
                               input ppu_pixel_t px, input logic pop);
    dotEn       = de;
    flush       = fl;
    lineStart   = ls;
    scxFine     = scx;
    bus.push_en = pe;
    bus.push_px = px;
    bus.pop_en  = pop;
    @(posedge clk);
    #1;
    modelStep(de, fl, ls, scx, pe, px, pop);
    checkOutput("model");
  endtask

  task automatic idleFlush();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0);
  endtask

  function automatic void addVec(input logic de, input logic fl, input logic pe, input int spr,
                                 input logic pop, input int cnt, input logic emp,
                                 input logic vld, input int hspr, input int hcol,
                                 input logic unf);
    vec_t v;
    v.de = de; v.fl = fl; v.pe = pe; v.spr = spr[5:0]; v.pop = pop;
    v.expCount = cnt; v.expEmpty = emp; v.expValid = vld;
    v.expHeadSpr = hspr[5:0]; v.expHeadCol = hcol[1:0]; v.expUnf = unf;
    vecs.push_back(v);
  endfunction

  initial begin
    ppu_pixel_t headPx;
    int         invisible;
    int         emitted[$];

    reset       = 1'b1;
    dotEn       = 1'b0;
    flush       = 1'b0;
    lineStart   = 1'b0;
    scxFine     = 3'd0;
    bus.push_en = 1'b0;
    bus.push_px = '0;
    bus.pop_en  = 1'b0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset.count", 32'(bus.count), 0);
    check("reset.empty", 32'(bus.empty), 1);
    check("reset.full", 32'(bus.full), 0);
    check("reset.outValid", 32'(bus.out_valid), 0);
    check("reset.outPx", 32'(bus.out_px), 0);
    check("reset.flags", {29'd0, discarding, overflow, underflow}, 0);
    reset = 1'b0;

    // Ordering table: 8 pushes, a gated dot, 8 pops, gated requests, underflow, flush.
    for (int i = 0; i < 8; i++) addVec(1, 0, 1, 10 + i, 0, i + 1, 0, 1, 10, 2, 0);
    addVec(0, 0, 1, 50, 1, 8, 0, 1, 10, 2, 0);
    for (int j = 0; j < 8; j++)
      addVec(1, 0, 0, 0, 1, 7 - j, j == 7, j != 7, (j < 7) ? 11 + j : 0, (j < 7) ? (11 + j) % 4 : 0, 0);
    addVec(0, 0, 1, 51, 1, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    addVec(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].de, vecs[i].fl, 1'b0, 3'd0, vecs[i].pe, mkPx(int'(vecs[i].spr)), vecs[i].pop);
      headPx = bus.out_px;
      check($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].expCount));
      check($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vecs[i].expEmpty));
      check($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      check($sformatf("vec%0d.headSpr", i), 32'(headPx.spr_idx), 32'(vecs[i].expHeadSpr));
      check($sformatf("vec%0d.headCol", i), 32'(headPx.color), 32'(vecs[i].expHeadCol));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].expUnf));
    end

    // Fill to full, drop the 17th push, then drain and confirm the first 16 only.
    idleFlush();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(i), 1'b0);
      if (i == 15) begin
        check("fill.full", 32'(bus.full), 1);
        check("fill.noOverflowYet", 32'(overflow), 0);
      end
    end
    check("fill.overflow", 32'(overflow), 1);
    check("fill.count", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) begin
      headPx = bus.out_px;
      check($sformatf("drain%0d.spr", i), 32'(headPx.spr_idx), 32'(i));
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b1);
    end
    check("drain.empty", 32'(bus.empty), 1);

    // Push and pop together at full: pop wins, push is dropped.
    idleFlush();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(i), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(40), 1'b1);
    headPx = bus.out_px;
    check("fullPushPop.count", 32'(bus.count), 15);
    check("fullPushPop.head", 32'(headPx.spr_idx), 1);
    check("fullPushPop.overflow", 32'(overflow), 1);

    // Push and pop together with a single entry: the new pixel becomes the head.
    idleFlush();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(20), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(21), 1'b1);
    headPx = bus.out_px;
    check("onePushPop.count", 32'(bus.count), 1);
    check("onePushPop.head", 32'(headPx.spr_idx), 21);

    // Fine scroll of 5 with a continuous supply and pop_en held high.
    idleFlush();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, '0, 1'b0);
    check("scroll.discarding", 32'(discarding), 1);
    invisible = 0;
    for (int c = 0; c < 12; c++) begin
      headPx = bus.out_px;
      if (!bus.empty && !bus.out_valid && discarding) invisible++;
      if (bus.out_valid) emitted.push_back(int'(headPx.spr_idx));
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, c < 8, mkPx(c), 1'b1);
    end
    check("scroll.invisibleDots", 32'(invisible), 5);
    check("scroll.emittedCount", 32'(emitted.size()), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("scroll.emit%0d", k), 32'((k < emitted.size()) ? emitted[k] : 99), 32'(5 + k));
    check("scroll.countEnd", 32'(bus.count), 0);

    // Flush mid-stream with pending discard, sticky underflow and a simultaneous push.
    idleFlush();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b1);
    check("midFlush.underflowSet", 32'(underflow), 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, mkPx(i), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, '0, 1'b0);
    check("midFlush.preCount", 32'(bus.count), 6);
    check("midFlush.preDiscarding", 32'(discarding), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, mkPx(33), 1'b0);
    check("midFlush.count", 32'(bus.count), 0);
    check("midFlush.discarding", 32'(discarding), 0);
    check("midFlush.empty", 32'(bus.empty), 1);
    check("midFlush.flags", {30'd0, overflow, underflow}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    check("midFlush.notStored", 32'(bus.count), 0);

    // Randomized run against the model, with one asynchronous reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        reset = 1'b1;
        #2;
        check("asyncReset.count", 32'(bus.count), 0);
        check("asyncReset.empty", 32'(bus.empty), 1);
        check("asyncReset.outPx", 32'(bus.out_px), 0);
        check("asyncReset.discarding", 32'(discarding), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
      end
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 29) == 0, 3'($urandom), $urandom_range(0, 9) < 6,
                    ppu_pixel_t'(13'($urandom)), $urandom_range(0, 9) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_bg_fifo.md
# ppu_bg_fifo

Background pixel FIFO for the PPU's mode-3 pixel pipeline. It is the receiving end of the background fetcher's push interface: it accepts one `ppu_pixel_t` per dot and reports `full`/`empty` back to the fetcher. It presents the head pixel to the pixel mixer and pops one pixel per dot on request. It also performs the SCX fine-scroll discard at the start of each scanline and is cleared on window start.

## Interface
- `DEPTH`, default 16: storage entries; must be a power of two and at least 8.
- `clk  in  1`: PPU dot clock.
- `reset  in  1`: asynchronous, active-high; clock is `clk`.
- `dot_en  in  1`: high only during mode 3. Push, pop and discard act only when it is high.
- `flush  in  1`: synchronous clear (window start / line end); acts regardless of `dot_en`.
- `line_start  in  1`: one-dot strobe at the first mode-3 dot of a line; loads the discard counter.
- `scx_fine  in  3`: `SCX[2:0]`, sampled on `line_start`.
- `push_en  in  1`: fetcher pushes `push_px` this dot.
- `push_px  in  $bits(ppu_pixel_t)`: pixel to store (`color`, `palette`, `spr_idx`, `bg_prio`, `valid`).
- `full  out  1`: `count == DEPTH`.
- `empty  out  1`: `count == 0`.
- `count  out  $clog2(DEPTH)+1`: current occupancy.
- `pop_en  in  1`: mixer consumes the head pixel this dot.
- `out_px  out  $bits(ppu_pixel_t)`: head entry; all-zero when `empty`.
- `out_valid  out  1`: `!empty && discard_cnt == 0`.
- `discarding  out  1`: `discard_cnt != 0`.
- `overflow  out  1`: sticky; set when a push is dropped.
- `underflow  out  1`: sticky; set when a pop is ignored. Both sticky flags clear only on `reset` or `flush`.

## Operation
- Storage is a circular buffer with `rd_ptr` and `wr_ptr`, each `$clog2(DEPTH)` bits and wrapping modulo `DEPTH`. `count` is kept as a separate register.
- **Push:** accepted when `dot_en && push_en && !full`. The entry at `wr_ptr` is written and `wr_ptr` increments. A push while full is dropped and sets `overflow`.
- **Pop:** accepted when `dot_en && pop_en && out_valid`, and `rd_ptr` increments. A pop while `!out_valid` is ignored. It sets `underflow` only if `empty`; a pop during discard is silently ignored.
- **Discard:** when `dot_en && discard_cnt != 0 && !empty`, the head is popped internally, `discard_cnt` decrements, and `pop_en` is ignored. At most one pixel is discarded per dot.
- **Simultaneous push and pop (or discard):** both act and `count` is unchanged. `full` and `empty` are evaluated on the pre-update `count`, so a push into a full FIFO is dropped even if a pop occurs the same dot.
- **`line_start`:** `discard_cnt <= scx_fine`. Pointers and `count` are not affected.
- **`flush`:**
  - Pointers, `count`, `discard_cnt` and the sticky flags go to 0, overriding any push or pop that dot.
  - If `line_start` is also high, `discard_cnt` loads `scx_fine` (`line_start` wins for the discard counter).
- **Reset values:** pointers, `count` and `discard_cnt` are 0; storage is all-zero.
  - Outputs: `empty`=1, `full`=0, `out_valid`=0, `out_px`=0, `discarding`=0, `overflow`=0, `underflow`=0.
- Reset asserted mid-line discards all contents immediately, asynchronously.

## Timing
- All state updates on posedge `clk`. `full`, `empty`, `count`, `out_valid` and `discarding` are registered-state derived, with no combinational path from `push_en` or `pop_en`.
- Push-to-visible latency is 1 dot: a pixel pushed at edge N into an empty, non-discarding FIFO gives `out_valid`=1 after edge N.
- `out_px` is a combinational read of `storage[rd_ptr]`, gated to zero when `empty`.
- Throughput is one push plus one pop (or discard) per dot, sustained.
- A line with `scx_fine`=k and a continuous supply spends exactly k dots with `out_valid`=0 after the first pixel arrives. The pixel with index k of the line is the first one presented.
- With `dot_en`=0, state is frozen except for `flush`, `line_start` and reset.

## Test plan
- **Reset, then basic ordering:** push 8 pixels with colors 0,1,2,3,0,1,2,3 (one per dot, no pops) -> `count`=8, `empty`=0; then pop 8 -> colors come out in the same order, `empty`=1 after the 8th pop.
- **Fill and overflow:** push 17 times with no pops -> `full`=1 after the 16th, the 17th is dropped, `overflow`=1, `count`=16; then pop 16 -> the first 16 pushed values only.
- **Fine scroll:** `line_start` with `scx_fine`=5, then 8 pushes and `pop_en` held high -> 5 dots with `out_valid`=0 and `discarding`=1, then pixels 5,6,7 emitted, `count`=0.
- **Simultaneous push/pop at full and at one entry:**
  - full FIFO + push + pop -> pop succeeds, push dropped, `count`=15.
  - `count`=1 + push + pop -> `count`=1, new pixel at head.
- **Flush mid-stream:** `count`=6, `discard_cnt`=2, assert `flush` with `push_en`=1 -> `count`=0, `discarding`=0, `empty`=1, `overflow`/`underflow` cleared, pushed pixel not stored.
- **`dot_en` gating and underflow:** `dot_en`=0 with push/pop requests -> no state change; `dot_en`=1 and pop while empty -> `underflow`=1, `count` stays 0.
